// File: rtl/multi_button_counter_pkg.sv
// Shared debounce FSM state type and default parameter values for multi_button_counter.
package multi_button_counter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } db_state_e;

  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_CNT_W           = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 480000;
  localparam int DEF_REPEAT_DELAY    = 24000000;
  localparam int DEF_REPEAT_PERIOD   = 4800000;

endpackage

// File: rtl/multi_button_counter_debounce.sv
// One button channel: 2-flop synchroniser, debounce FSM and stability down-counter.
// Optional auto-repeat timer is built only when AUTO_REPEAT_EN is defined.
//
// state      | meaning
// IDLE       | button released and accepted as released
// PRESS_DB   | low seen, waiting for DEBOUNCE_CYCLES more stable low cycles
// HELD       | press accepted, button still down
// RELEASE_DB | high seen while held, waiting for a stable release
module button_debounce_ch
  import multi_button_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic event_o
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES);

  logic            sync1_q, sync2_q;
  db_state_e       state_q, state_d;
  logic [DB_W-1:0] stab_q, stab_d;
  logic            accept;
  logic            rpt_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      stab_q  <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sync2_q) begin
          state_d = PRESS_DB;
          stab_d  = DB_LOAD;
        end
      end
      PRESS_DB: begin
        if (sync2_q) begin
          state_d = IDLE;
          stab_d  = '0;
        end else if (stab_q == '0) begin
          state_d = HELD;
          accept  = 1'b1;
        end else begin
          stab_d = stab_q - DB_W'(1);
        end
      end
      HELD: begin
        if (sync2_q) begin
          state_d = RELEASE_DB;
          stab_d  = DB_LOAD;
        end
      end
      RELEASE_DB: begin
        if (!sync2_q) begin
          state_d = HELD;
          stab_d  = '0;
        end else if (stab_q == '0) begin
          state_d = IDLE;
        end else begin
          stab_d = stab_q - DB_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        stab_d  = '0;
      end
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;

  // Timer is reloaded on every entry into HELD, so a bounce restarts the delay.
  always_comb begin
    rpt_d    = '0;
    rpt_fire = 1'b0;
    if (state_d == HELD) begin
      if (state_q != HELD) begin
        rpt_d = RPT_W'(REPEAT_DELAY - 1);
      end else if (rpt_q == '0) begin
        rpt_fire = 1'b1;
        rpt_d    = RPT_W'(REPEAT_PERIOD - 1);
      end else begin
        rpt_d = rpt_q - RPT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rpt_q <= '0;
    else     rpt_q <= rpt_d;
  end
`else
  assign rpt_fire = 1'b0;
`endif

  assign event_o = accept | rpt_fire;

endmodule

// File: rtl/multi_button_counter.sv
// NUM_CH debounced buttons, each driving a wrapping up/down counter with clear.
// Define AUTO_REPEAT_EN to enable auto-repeat while a button is held.
module multi_button_counter
  import multi_button_counter_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int CNT_W           = DEF_CNT_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       btn_n,
  input  logic [NUM_CH-1:0]       dir,
  input  logic [NUM_CH-1:0]       clr,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       press,
  output logic [NUM_CH-1:0]       wrap
);

  logic [NUM_CH*CNT_W-1:0] count_q, count_d;
  logic [NUM_CH-1:0]       evt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_n  (btn_n[g]),
      .event_o(evt[g])
    );
  end

  // Clear has priority over a same-cycle event and suppresses its wrap.
  always_comb begin
    count_d = count_q;
    wrap    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (clr[i]) begin
        count_d[i*CNT_W +: CNT_W] = '0;
      end else if (evt[i]) begin
        if (dir[i]) begin
          count_d[i*CNT_W +: CNT_W] = count_q[i*CNT_W +: CNT_W] - CNT_W'(1);
          wrap[i] = (count_q[i*CNT_W +: CNT_W] == '0);
        end else begin
          count_d[i*CNT_W +: CNT_W] = count_q[i*CNT_W +: CNT_W] + CNT_W'(1);
          wrap[i] = (count_q[i*CNT_W +: CNT_W] == '1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign press = evt;

endmodule

// File: tb/tb_multi_button_counter.sv
// Randomised and directed bench for multi_button_counter with a scoreboard of expected events.
module tb_multi_button_counter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 4;
  localparam int DB     = 8;
  localparam int RD     = 20;
  localparam int RP     = 10;
  localparam int MODV   = 1 << CNT_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NUM_CH-1:0]       btn_n = '1;
  logic [NUM_CH-1:0]       dir = '0;
  logic [NUM_CH-1:0]       clr = '0;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       press;
  logic [NUM_CH-1:0]       wrap;

  int checks = 0;
  int failures = 0;

  multi_button_counter #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .dir(dir), .clr(clr),
    .count(count), .press(press), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  typedef struct {
    int cyc;
    int ch;
    int wr;
    int cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a level change is accepted once the synchronised level has
  // differed from the accepted level for DB+2 consecutive cycles; accepting a
  // press is a count event.
  int          cyc = 0;
  logic [NUM_CH-1:0] m_cap;
  logic        m_rcap;
  int          m_s1[NUM_CH], m_s2[NUM_CH], m_acc[NUM_CH], m_broken[NUM_CH];
  int          m_run[NUM_CH], m_k[NUM_CH], m_cnt[NUM_CH];
  int          m_lvl, m_ev, m_nc, m_w;

  always begin
    @(posedge clk);
    m_cap  = btn_n;
    m_rcap = rst;
    cyc++;
    #2;
    if (m_rcap) exp_q.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      if (m_rcap) begin
        m_s1[c] = 1; m_s2[c] = 1; m_acc[c] = 1; m_broken[c] = 0;
        m_run[c] = 0; m_k[c] = 0; m_cnt[c] = 0;
      end else begin
        m_s2[c] = m_s1[c];
        m_s1[c] = int'(m_cap[c]);
        m_lvl = m_s2[c];
        m_ev = 0;
        if (m_lvl != m_acc[c]) begin
          m_run[c]++;
          if (m_run[c] == DB + 2) begin
            m_ev = m_acc[c];
            m_acc[c] = 1 - m_acc[c];
            m_run[c] = 0; m_k[c] = 0; m_broken[c] = 0;
          end
        end else begin
          m_run[c] = 0;
        end
`ifdef AUTO_REPEAT_EN
        if (m_ev == 0 && m_acc[c] == 0) begin
          if (m_lvl == 1) m_broken[c] = 1;
          else if (m_broken[c] == 1) begin m_broken[c] = 0; m_k[c] = 0; end
          else begin
            m_k[c]++;
            if (m_k[c] >= RD && (m_k[c] - RD) % RP == 0) m_ev = 1;
          end
        end
`endif
        if (m_ev == 1) begin
          if (clr[c]) begin m_nc = 0; m_w = 0; end
          else if (dir[c]) begin m_w = (m_cnt[c] == 0); m_nc = (m_cnt[c] + MODV - 1) % MODV; end
          else begin m_w = (m_cnt[c] == MODV - 1); m_nc = (m_cnt[c] + 1) % MODV; end
          m_cnt[c] = m_nc;
          exp_q.push_back('{cyc, c, m_w, m_nc});
        end else if (clr[c]) begin
          m_cnt[c] = 0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT pulses press.
  int pend_v[NUM_CH], pend_cnt[NUM_CH];
  int n_press[NUM_CH], n_wrap[NUM_CH], last_press[NUM_CH];
  int have;

  initial for (int c = 0; c < NUM_CH; c++) begin
    pend_v[c] = 0; n_press[c] = 0; n_wrap[c] = 0; last_press[c] = -1;
  end

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check($sformatf("stale_event ch%0d cyc%0d", exp_q[0].ch, exp_q[0].cyc), 0, 1);
      void'(exp_q.pop_front());
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (pend_v[c] != 0) begin
        check($sformatf("count_after_press ch%0d", c), int'(count[c*CNT_W +: CNT_W]), pend_cnt[c]);
        pend_v[c] = 0;
      end
      have = (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].ch == c) ? 1 : 0;
      if (press[c] || have != 0) begin
        check($sformatf("press ch%0d cyc%0d", c, cyc), int'(press[c]), have);
        if (press[c] && have != 0) begin
          check($sformatf("wrap ch%0d cyc%0d", c, cyc), int'(wrap[c]), exp_q[0].wr);
          pend_v[c] = 1;
          pend_cnt[c] = exp_q[0].cnt;
        end
        if (have != 0) void'(exp_q.pop_front());
      end
      if (wrap[c] && !press[c]) check($sformatf("wrap_without_press ch%0d", c), int'(wrap[c]), 0);
      if (press[c]) begin n_press[c]++; last_press[c] = cyc; end
      if (wrap[c]) n_wrap[c]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_btn(input int c);
    btn_n[c] = 1'b0;
    tick(DB + 6);
    btn_n[c] = 1'b1;
    tick(DB + 6);
  endtask

  int fall_edge, snap[NUM_CH], np0, hold[NUM_CH];

  initial begin
    rst = 1'b1;
    tick(3);
    check("reset_count", int'(count), 0);
    check("reset_press", int'(press), 0);
    check("reset_wrap", int'(wrap), 0);
    rst = 1'b0;
    tick(2);

    // Single stable press: latency and one event
    fall_edge = cyc + 1;
    btn_n[0] = 1'b0;
    tick(20);
    btn_n[0] = 1'b1;
    tick(15);
    check("latency_ch0", last_press[0] - fall_edge, DB + 2);
    check("presses_ch0", n_press[0], 1);
    check("count_ch0_single", int'(count[0 +: CNT_W]), 1);

    // Short glitches never accepted
    for (int i = 0; i < 6; i++) begin
      btn_n[1] = 1'b0; tick(5);
      btn_n[1] = 1'b1; tick(5);
    end
    tick(5);
    check("glitch_presses_ch1", n_press[1], 0);
    check("glitch_count_ch1", int'(count[1*CNT_W +: CNT_W]), 0);

    // Wrap up then down on channel 2
    for (int i = 0; i < MODV - 1; i++) press_btn(2);
    check("count_ch2_full", int'(count[2*CNT_W +: CNT_W]), MODV - 1);
    press_btn(2);
    check("count_ch2_wrap_up", int'(count[2*CNT_W +: CNT_W]), 0);
    check("wraps_ch2_up", n_wrap[2], 1);
    dir[2] = 1'b1;
    press_btn(2);
    check("count_ch2_wrap_down", int'(count[2*CNT_W +: CNT_W]), MODV - 1);
    check("wraps_ch2_down", n_wrap[2], 2);
    dir[2] = 1'b0;

    // Clear wins in the press cycle; other channels count simultaneously
    for (int i = 0; i < 4; i++) press_btn(0);
    check("count_ch0_five", int'(count[0 +: CNT_W]), 5);
    for (int c = 0; c < NUM_CH; c++) snap[c] = m_cnt[c];
    np0 = n_wrap[0];
    fall_edge = cyc + 1;
    btn_n = '0;
    tick(DB + 3);
    clr[0] = 1'b1;
    tick(1);
    clr[0] = 1'b0;
    tick(2);
    check("clr_count_ch0", int'(count[0 +: CNT_W]), 0);
    check("clr_wrap_ch0", n_wrap[0] - np0, 0);
    check("clr_press_cycle_ch0", last_press[0] - fall_edge, DB + 2);
    for (int c = 1; c < NUM_CH; c++) begin
      check($sformatf("simul_count ch%0d", c), int'(count[c*CNT_W +: CNT_W]), (snap[c] + 1) % MODV);
      check($sformatf("simul_cycle ch%0d", c), last_press[c] - fall_edge, DB + 2);
    end
    btn_n = '1;
    tick(DB + 6);

    // Reset mid-debounce, button still held afterwards
    btn_n[1] = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(2);
    check("rst_mid_count", int'(count), 0);
    check("rst_mid_press", int'(press), 0);
    check("rst_mid_wrap", int'(wrap), 0);
    rst = 1'b0;
    fall_edge = cyc + 1;
    np0 = n_press[1];
    tick(20);
    check("post_rst_latency_ch1", last_press[1] - fall_edge, DB + 2);
    check("post_rst_presses_ch1", n_press[1] - np0, 1);
    check("post_rst_count_ch1", int'(count[1*CNT_W +: CNT_W]), 1);
    btn_n[1] = 1'b1;
    tick(DB + 6);

    // Long hold on channel 3
    btn_n[3] = 1'b0;
    tick(72);
    btn_n[3] = 1'b1;
    tick(DB + 6);
`ifdef AUTO_REPEAT_EN
    check("long_hold_count_ch3", int'(count[3*CNT_W +: CNT_W]), 6);
`else
    check("long_hold_count_ch3", int'(count[3*CNT_W +: CNT_W]), 1);
`endif

    // Random traffic
    for (int c = 0; c < NUM_CH; c++) hold[c] = $urandom_range(1, 30);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          btn_n[c] = ~btn_n[c];
          hold[c] = $urandom_range(1, 30);
        end
        dir[c] = $urandom_range(0, 1) == 1;
        clr[c] = $urandom_range(0, 63) == 0;
      end
      tick(1);
    end
    btn_n = '1;
    clr = '0;
    tick(DB + 8);
    for (int c = 0; c < NUM_CH; c++)
      check($sformatf("final_count ch%0d", c), int'(count[c*CNT_W +: CNT_W]), m_cnt[c]);
    check("leftover_events", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
